friscv_dispatch_scoreboard: RTL

// - Buffers decoded instructions in an in-order queue and issues the queue head to one of NB_UNIT execution units.
// - Holds issue while a RAW/WAW hazard is pending, tracked by per-register reservation counters.
// - Generalises the processing-unit reservation logic: any unit count, any queue depth, real stall/issue control, error flags.
// - Sits between the control unit's instruction bus and the ALU/memfy/M/F execution units.

---
 rtl/friscv_dispatch_scoreboard.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/friscv_dispatch_scoreboard.sv
// In-order dispatch queue with per-register reservation counters for RAW/WAW hazard tracking.
// Optional hazard-stall statistics counter enabled by defining FRISCV_DISPATCH_STATS_EN.
module friscv_dispatch_scoreboard #(
  parameter int unsigned NB_UNIT     = 4,
  parameter int unsigned INST_W      = 128,
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter int unsigned CNT_W       = 3,
  parameter int unsigned NB_REG      = 32,
  localparam int unsigned UNIT_W     = (NB_UNIT > 1) ? $clog2(NB_UNIT) : 1
) (
  input  logic                 aclk,
  input  logic                 srst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [INST_W-1:0]    in_inst,
  input  logic [UNIT_W-1:0]    in_unit,
  input  logic [4:0]           in_rs1,
  input  logic [4:0]           in_rs2,
  input  logic [4:0]           in_rd,
  input  logic                 in_rd_en,
  output logic [NB_UNIT-1:0]   out_valid,
  input  logic [NB_UNIT-1:0]   out_ready,
  output logic [INST_W-1:0]    out_inst,
  input  logic [NB_UNIT-1:0]   wb_wr,
  input  logic [NB_UNIT*5-1:0] wb_addr,
  output logic [NB_REG-1:0]    rsvd_regs,
  output logic                 busy,
  output logic [1:0]           err,
  output logic [31:0]          stall_cnt
);

  localparam int unsigned PTR_W   = $clog2(QUEUE_DEPTH);
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  // Queue storage (payload fields are not reset; validity comes from r_count)
  logic [INST_W-1:0] r_q_inst  [QUEUE_DEPTH];
  logic [UNIT_W-1:0] r_q_unit  [QUEUE_DEPTH];
  logic [4:0]        r_q_rs1   [QUEUE_DEPTH];
  logic [4:0]        r_q_rs2   [QUEUE_DEPTH];
  logic [4:0]        r_q_rd    [QUEUE_DEPTH];
  logic              r_q_rd_en [QUEUE_DEPTH];

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;

  logic [CNT_W-1:0]  r_cnt     [NB_REG];
  logic [CNT_W-1:0]  w_cnt_nxt [NB_REG];
  logic [1:0]        r_err;

  logic              w_empty;
  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic              w_issue;
  logic              w_hazard;
  logic              w_bad_unit;
  logic              w_underflow;

  logic [UNIT_W-1:0] w_head_unit;
  logic [4:0]        w_head_rs1;
  logic [4:0]        w_head_rs2;
  logic [4:0]        w_head_rd;
  logic              w_head_rd_en;

  logic [NB_REG-1:0] w_rsvd;
  logic [31:0]       w_rsvd_ext;
  logic [31:0]       w_max_ext;
  int                w_sum;
  int                w_dec;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == (PTR_W+1)'(QUEUE_DEPTH));
  assign in_ready = !w_full;
  assign w_push   = in_valid && in_ready && !flush;

  assign w_head_unit  = r_q_unit[r_rd_ptr];
  assign w_head_rs1   = r_q_rs1[r_rd_ptr];
  assign w_head_rs2   = r_q_rs2[r_rd_ptr];
  assign w_head_rd    = r_q_rd[r_rd_ptr];
  assign w_head_rd_en = r_q_rd_en[r_rd_ptr];
  assign out_inst     = r_q_inst[r_rd_ptr];

  // Reservation status widened to the full 5-bit register address space
  always_comb begin
    w_rsvd     = '0;
    w_rsvd_ext = '0;
    w_max_ext  = '0;
    for (int r = 1; r < NB_REG; r++) begin
      w_rsvd[r]     = (r_cnt[r] != '0);
      w_rsvd_ext[r] = (r_cnt[r] != '0);
      w_max_ext[r]  = (r_cnt[r] == CNT_W'(CNT_MAX));
    end
  end

  assign rsvd_regs = w_rsvd;
  assign busy      = !w_empty || (|w_rsvd);
  assign err       = r_err;

  always_comb begin
    w_hazard = 1'b0;
    if (w_head_rs1 != 5'd0 && w_rsvd_ext[w_head_rs1]) w_hazard = 1'b1;
    if (w_head_rs2 != 5'd0 && w_rsvd_ext[w_head_rs2]) w_hazard = 1'b1;
    if (w_head_rd_en && w_head_rd != 5'd0 &&
        (w_rsvd_ext[w_head_rd] || w_max_ext[w_head_rd])) begin
      w_hazard = 1'b1;
    end
  end

  // Out-of-range unit index drains the head without issuing it
  assign w_bad_unit = !w_empty && (32'(w_head_unit) >= NB_UNIT);

  always_comb begin
    out_valid = '0;
    if (!w_empty && !w_hazard && !w_bad_unit) begin
      out_valid[w_head_unit] = 1'b1;
    end
  end

  assign w_issue = |(out_valid & out_ready);
  assign w_pop   = w_issue || w_bad_unit;

  always_ff @(posedge aclk) begin
    if (srst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (w_push) begin
      r_q_inst[r_wr_ptr]  <= in_inst;
      r_q_unit[r_wr_ptr]  <= in_unit;
      r_q_rs1[r_wr_ptr]   <= in_rs1;
      r_q_rs2[r_wr_ptr]   <= in_rs2;
      r_q_rd[r_wr_ptr]    <= in_rd;
      r_q_rd_en[r_wr_ptr] <= in_rd_en;
    end
  end

  // Issue increment and all write-back decrements combine before clamping
  always_comb begin
    w_underflow = 1'b0;
    w_sum       = 0;
    w_dec       = 0;
    for (int r = 0; r < NB_REG; r++) begin
      w_dec = 0;
      for (int u = 0; u < NB_UNIT; u++) begin
        if (wb_wr[u] && (wb_addr[u*5 +: 5] == 5'(r))) w_dec = w_dec + 1;
      end
      w_sum = int'(r_cnt[r]) - w_dec;
      if (w_issue && w_head_rd_en && (w_head_rd == 5'(r))) w_sum = w_sum + 1;
      if (r == 0) begin
        w_cnt_nxt[r] = '0;
      end else if (w_sum < 0) begin
        w_cnt_nxt[r] = '0;
        w_underflow  = 1'b1;
      end else if (w_sum > CNT_MAX) begin
        w_cnt_nxt[r] = CNT_W'(CNT_MAX);
      end else begin
        w_cnt_nxt[r] = CNT_W'(w_sum);
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (srst) begin
      for (int r = 0; r < NB_REG; r++) r_cnt[r] <= '0;
      r_err <= '0;
    end else begin
      for (int r = 0; r < NB_REG; r++) r_cnt[r] <= w_cnt_nxt[r];
      r_err <= r_err | {w_bad_unit, w_underflow};
    end
  end

`ifdef FRISCV_DISPATCH_STATS_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge aclk) begin
    if (srst) begin
      r_stall_cnt <= '0;
    end else if (!w_empty && w_hazard && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = '0;
`endif

endmodule
